// File: rtl/foc_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// foc_cmd_sequencer_if
//
// Purpose
//   Groups the handshake signals between the command sequencer, the two
//   show-ahead command FIFOs feeding it and the FOC core it launches.
//
// Signals
//   empty_opcode  opcode FIFO empty
//   fifo_opcode   opcode FIFO head word (8 bit, show-ahead)
//   rd_en_opcode  opcode FIFO pop strobe (one word per cycle)
//   empty_data    data FIFO empty
//   fifo_data     data FIFO head word (D_WIDTH bit, show-ahead)
//   rd_en_data    data FIFO pop strobe (one word per cycle)
//   foc_valid     one-cycle frame-ready pulse towards the FOC core
//   foc_ready     FOC core idle/done
//
// Modports
//   master  the sequencer: consumes FIFO heads, drives the pops and foc_valid
//   slave   the FIFOs plus the FOC core side
// -----------------------------------------------------------------------------
interface foc_cmd_sequencer_if #(
    parameter int D_WIDTH = 16
) ();
    logic               empty_opcode;
    logic [7:0]         fifo_opcode;
    logic               rd_en_opcode;
    logic               empty_data;
    logic [D_WIDTH-1:0] fifo_data;
    logic               rd_en_data;
    logic               foc_valid;
    logic               foc_ready;

    modport master (
        input  empty_opcode,
        input  fifo_opcode,
        input  empty_data,
        input  fifo_data,
        input  foc_ready,
        output rd_en_opcode,
        output rd_en_data,
        output foc_valid
    );

    modport slave (
        output empty_opcode,
        output fifo_opcode,
        output empty_data,
        output fifo_data,
        output foc_ready,
        input  rd_en_opcode,
        input  rd_en_data,
        input  foc_valid
    );
endinterface

// File: rtl/foc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// foc_cmd_sequencer
//
// Purpose
//   Pulls opcodes and data words out of two show-ahead FIFOs and turns them
//   into configuration updates and sample frames for a FOC core.
//     0x00  load all N_CFG configuration registers (atomic commit)
//     0x01  load one configuration register: index word, then value word
//     0x02  clear all sticky error flags
//     0xFF  load an N_SAMP-word sample frame, pulse foc_valid, wait for
//           the core to report done
//     other popped and discarded, err_opcode set
//
// Optional feature
//   FOC_CMD_TIMEOUT_EN  when defined, a watchdog bounds the wait for the FOC
//                       core to TIMEOUT_CYC cycles and reports err_timeout.
//                       When undefined the wait is unbounded and err_timeout
//                       is tied low.
//
// Ports
//   clk_sys      system clock
//   rstb         asynchronous active-low reset
//   bus          foc_cmd_sequencer_if.master (FIFO pops/heads, foc_valid/ready)
//   cfg_bus      committed configuration, register i at [i*D_WIDTH +: D_WIDTH]
//   samp_bus     latched sample frame, packed like cfg_bus
//   ready        high when no frame is in flight
//   err_opcode   sticky: unknown opcode seen
//   err_index    sticky: single-register load aimed past N_CFG-1
//   err_timeout  sticky: FOC core did not finish in time (optional feature)
//   frame_cnt    completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module foc_cmd_sequencer #(
    parameter int D_WIDTH     = 16,
    parameter int N_CFG       = 5,
    parameter int N_SAMP      = 5,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                        clk_sys,
    input  logic                        rstb,
    foc_cmd_sequencer_if.master         bus,
    output logic [N_CFG*D_WIDTH-1:0]    cfg_bus,
    output logic [N_SAMP*D_WIDTH-1:0]   samp_bus,
    output logic                        ready,
    output logic                        err_opcode,
    output logic                        err_index,
    output logic                        err_timeout,
    output logic [15:0]                 frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CFG,
        LOAD_IDX,
        LOAD_ONE,
        LOAD_SAMP,
        WAIT_FOC
    } state_t;

    localparam logic [7:0] OP_LOAD_CFG = 8'h00;
    localparam logic [7:0] OP_LOAD_ONE = 8'h01;
    localparam logic [7:0] OP_CLR_ERR  = 8'h02;
    localparam logic [7:0] OP_FRAME    = 8'hFF;

    localparam logic [D_WIDTH-1:0] LAST_CFG  = D_WIDTH'(N_CFG - 1);
    localparam logic [D_WIDTH-1:0] LAST_SAMP = D_WIDTH'(N_SAMP - 1);
    localparam logic [D_WIDTH-1:0] CFG_LIMIT = D_WIDTH'(N_CFG);

    state_t             state;
    // Word counter during block loads; holds the target register in LOAD_ONE.
    logic [D_WIDTH-1:0] idx;
    logic [D_WIDTH-1:0] shadow [N_CFG];
    logic               foc_valid_q;
    logic               load_st;
    logic               pop_op;
    logic               pop_data;
    logic [D_WIDTH-1:0] data_head;

`ifdef FOC_CMD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0]    watchdog;
    logic               err_timeout_q;

    assign err_timeout = err_timeout_q;
`else
    // Keeps the parameter referenced when the watchdog is compiled out.
    logic [31:0]        unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign err_timeout        = 1'b0;
`endif

    assign data_head = bus.fifo_data;
    assign load_st   = (state == LOAD_CFG) || (state == LOAD_IDX) ||
                       (state == LOAD_ONE) || (state == LOAD_SAMP);

    // Pops are combinational so the show-ahead head is consumed at the very
    // edge where it is decoded; an empty FIFO simply stalls the state.
    assign pop_op    = (state == IDLE) && !bus.empty_opcode;
    assign pop_data  = load_st && !bus.empty_data;

    assign bus.rd_en_opcode = pop_op;
    assign bus.rd_en_data   = pop_data;
    assign bus.foc_valid    = foc_valid_q;

    always_ff @(posedge clk_sys or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            idx         <= '0;
            cfg_bus     <= '0;
            samp_bus    <= '0;
            foc_valid_q <= 1'b0;
            ready       <= 1'b1;
            err_opcode  <= 1'b0;
            err_index   <= 1'b0;
            frame_cnt   <= '0;
            for (int i = 0; i < N_CFG; i++) begin
                shadow[i] <= '0;
            end
`ifdef FOC_CMD_TIMEOUT_EN
            err_timeout_q <= 1'b0;
            watchdog      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop_op) begin
                        case (bus.fifo_opcode)
                            OP_LOAD_CFG: begin
                                idx   <= '0;
                                state <= LOAD_CFG;
                            end
                            OP_LOAD_ONE: begin
                                state <= LOAD_IDX;
                            end
                            OP_CLR_ERR: begin
                                err_opcode <= 1'b0;
                                err_index  <= 1'b0;
`ifdef FOC_CMD_TIMEOUT_EN
                                err_timeout_q <= 1'b0;
`endif
                            end
                            OP_FRAME: begin
                                ready <= 1'b0;
                                idx   <= '0;
                                state <= LOAD_SAMP;
                            end
                            default: begin
                                err_opcode <= 1'b1;
                            end
                        endcase
                    end
                end

                LOAD_CFG: begin
                    if (pop_data) begin
                        for (int i = 0; i < N_CFG; i++) begin
                            if (idx == D_WIDTH'(i)) begin
                                shadow[i] <= data_head;
                            end
                        end
                        // Last word goes straight to cfg_bus together with the
                        // earlier shadow words, so the set commits on one edge.
                        if (idx == LAST_CFG) begin
                            for (int i = 0; i < N_CFG - 1; i++) begin
                                cfg_bus[i*D_WIDTH +: D_WIDTH] <= shadow[i];
                            end
                            cfg_bus[(N_CFG-1)*D_WIDTH +: D_WIDTH] <= data_head;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                LOAD_IDX: begin
                    if (pop_data) begin
                        idx   <= data_head;
                        state <= LOAD_ONE;
                    end
                end

                LOAD_ONE: begin
                    if (pop_data) begin
                        if (idx < CFG_LIMIT) begin
                            for (int i = 0; i < N_CFG; i++) begin
                                if (idx == D_WIDTH'(i)) begin
                                    cfg_bus[i*D_WIDTH +: D_WIDTH] <= data_head;
                                end
                            end
                        end else begin
                            err_index <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end

                LOAD_SAMP: begin
                    if (pop_data) begin
                        for (int i = 0; i < N_SAMP; i++) begin
                            if (idx == D_WIDTH'(i)) begin
                                samp_bus[i*D_WIDTH +: D_WIDTH] <= data_head;
                            end
                        end
                        if (idx == LAST_SAMP) begin
                            foc_valid_q <= 1'b1;
                            state       <= WAIT_FOC;
`ifdef FOC_CMD_TIMEOUT_EN
                            watchdog    <= '0;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                WAIT_FOC: begin
                    foc_valid_q <= 1'b0;
                    // foc_ready is only trusted once the launch pulse has
                    // dropped, so an idle core cannot complete a frame it
                    // has not yet been handed.
                    if (bus.foc_ready && !foc_valid_q) begin
                        ready     <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end
`ifdef FOC_CMD_TIMEOUT_EN
                    else if (watchdog == WD_LAST) begin
                        err_timeout_q <= 1'b1;
                        ready         <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_foc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_foc_cmd_sequencer
//
// Bench for foc_cmd_sequencer. Queues model the two show-ahead FIFOs; a
// table of command records with cumulative expected outputs, a few
// hand-written multi-cycle sequences, and a randomized command stream
// checked against a command-level model of the register file.
// -----------------------------------------------------------------------------
module tb_foc_cmd_sequencer;

    localparam int DW = 16;
    localparam int NC = 5;
    localparam int NS = 5;
`ifdef FOC_CMD_TIMEOUT_EN
    localparam int TCYC = 16;
`else
    localparam int TCYC = 4096;
`endif

    logic clk_sys = 1'b0;
    logic rstb    = 1'b0;
    always #5 clk_sys = ~clk_sys;

    foc_cmd_sequencer_if #(.D_WIDTH(DW)) bus ();

    logic [NC*DW-1:0] cfg_bus;
    logic [NS*DW-1:0] samp_bus;
    logic             ready;
    logic             err_opcode;
    logic             err_index;
    logic             err_timeout;
    logic [15:0]      frame_cnt;

    foc_cmd_sequencer #(
        .D_WIDTH(DW), .N_CFG(NC), .N_SAMP(NS), .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk_sys    (clk_sys),
        .rstb       (rstb),
        .bus        (bus),
        .cfg_bus    (cfg_bus),
        .samp_bus   (samp_bus),
        .ready      (ready),
        .err_opcode (err_opcode),
        .err_index  (err_index),
        .err_timeout(err_timeout),
        .frame_cnt  (frame_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]    opq[$];
    logic [DW-1:0] dq[$];
    bit            stall_en  = 1'b0;
    bit            stall_now = 1'b0;
    bit            rnd_ready = 1'b0;
    int            vcount    = 0;
    int            vdouble   = 0;
    bit            prev_v    = 1'b0;

    // ---------------- FIFO model ----------------
    task automatic refresh();
        bus.empty_opcode = (opq.size() == 0);
        bus.fifo_opcode  = (opq.size() != 0) ? opq[0] : 8'h00;
        bus.empty_data   = (dq.size() == 0) || stall_now;
        bus.fifo_data    = (dq.size() != 0) ? dq[0] : '0;
    endtask

    task automatic push_op(input logic [7:0] op);
        opq.push_back(op);
        refresh();
    endtask

    task automatic push_d(input logic [DW-1:0] w);
        dq.push_back(w);
        refresh();
    endtask

    always @(posedge clk_sys) begin
        if (rstb && bus.rd_en_opcode === 1'b1 && opq.size() != 0) void'(opq.pop_front());
        if (rstb && bus.rd_en_data === 1'b1 && dq.size() != 0) void'(dq.pop_front());
        #1;
        stall_now = stall_en && ($urandom_range(0, 2) == 0);
        if (rnd_ready) bus.foc_ready = ($urandom_range(0, 3) != 0);
        refresh();
    end

    always @(negedge clk_sys) begin
        if (bus.foc_valid === 1'b1) begin
            vcount++;
            if (prev_v) vdouble++;
        end
        prev_v = (bus.foc_valid === 1'b1);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [79:0] ecfg, input logic [79:0] esamp,
                             input logic eeo, input logic eei, input logic eet,
                             input logic [15:0] efc, input logic erdy);
        chk({nm, ".cfg_bus"}, cfg_bus, ecfg);
        chk({nm, ".samp_bus"}, samp_bus, esamp);
        chk({nm, ".err_opcode"}, 80'(err_opcode), 80'(eeo));
        chk({nm, ".err_index"}, 80'(err_index), 80'(eei));
        chk({nm, ".err_timeout"}, 80'(err_timeout), 80'(eet));
        chk({nm, ".frame_cnt"}, 80'(frame_cnt), 80'(efc));
        chk({nm, ".ready"}, 80'(ready), 80'(erdy));
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (n < budget && quiet < 3) begin
            @(negedge clk_sys);
            n++;
            if (opq.size() == 0 && dq.size() == 0 && ready === 1'b1 && bus.foc_valid === 1'b0)
                quiet++;
            else
                quiet = 0;
        end
        checks++;
        if (quiet < 3) begin
            failures++;
            $display("FAIL %s.idle_wait: not idle after %0d cycles, required idle", nm, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rstb = 1'b0;
        opq.delete();
        dq.delete();
        stall_en  = 1'b0;
        stall_now = 1'b0;
        refresh();
        repeat (2) @(negedge clk_sys);
        rstb = 1'b1;
        @(negedge clk_sys);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]       op;
        int               nd;
        logic [4:0][15:0] d;
        logic [79:0]      cfg;
        logic [79:0]      samp;
        logic             eo;
        logic             ei;
        logic [15:0]      fc;
    } vec_t;

    function automatic vec_t mkv(input logic [7:0] op, input int nd, input logic [79:0] d,
                                 input logic [79:0] cfg, input logic [79:0] samp,
                                 input logic eo, input logic ei, input logic [15:0] fc);
        vec_t v;
        v.op = op; v.nd = nd; v.d = d; v.cfg = cfg; v.samp = samp;
        v.eo = eo; v.ei = ei; v.fc = fc;
        return v;
    endfunction

    initial begin : watchdog_blk
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "bench time limit");
    end

    initial begin : main
        vec_t          vt[13];
        logic [79:0]   c0, c1, c2, c3, s1, s2, s3, z;
        logic [15:0]   w5[5];
        logic [15:0]   m_cfg[5];
        logic [15:0]   m_samp[5];
        logic [79:0]   pk_cfg, pk_samp;
        logic          m_eo, m_ei;
        logic [15:0]   m_fc;
        logic [15:0]   w, idx;
        logic [7:0]    op;
        int            r, n, pulses, vcyc, rcyc, v0;

        bus.foc_ready = 1'b1;
        refresh();
        z = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk_sys);
        check_all("reset", z, z, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        chk("reset.foc_valid", 80'(bus.foc_valid), 80'd0);
        rstb = 1'b1;
        @(negedge clk_sys);

        // ---------------- atomic configuration commit ----------------
        w5 = '{16'h0100, 16'h0020, 16'h0200, 16'h0040, 16'h07D0};
        c0 = {16'h07D0, 16'h0040, 16'h0200, 16'h0020, 16'h0100};
        push_op(8'h00);
        for (int k = 0; k < 5; k++) begin
            push_d(w5[k]);
            n = 0;
            while (dq.size() != 0 && n < 20) begin
                @(negedge clk_sys);
                n++;
            end
            chk($sformatf("atomic.pop%0d_done", k), 80'(dq.size()), 80'd0);
            chk($sformatf("atomic.cfg_after_pop%0d", k), cfg_bus, (k < 4) ? z : c0);
        end
        chk("atomic.err_opcode", 80'(err_opcode), 80'd0);
        chk("atomic.err_index", 80'(err_index), 80'd0);

        // ---------------- frame handshake timing ----------------
        push_op(8'hFF);
        push_d(16'h1000); push_d(16'hF000); push_d(16'h0000); push_d(16'h0800); push_d(16'h4000);
        @(negedge clk_sys);
        chk("frame.ready_low_after_opcode_pop", 80'(ready), 80'd0);
        pulses = 0; vcyc = -1; rcyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_sys);
            if (bus.foc_valid === 1'b1) begin
                pulses++;
                vcyc = k;
            end
            if (ready === 1'b1) begin
                rcyc = k;
                break;
            end
        end
        chk("frame.valid_pulses", 80'(pulses), 80'd1);
        chk("frame.ready_after_valid", 80'(rcyc > vcyc && vcyc >= 0), 80'd1);
        chk("frame.frame_cnt", 80'(frame_cnt), 80'd1);
        chk("frame.samp_bus", samp_bus, {16'h4000, 16'h0800, 16'h0000, 16'hF000, 16'h1000});

        // ---------------- table-driven command vectors ----------------
        do_reset();
        c1 = {16'h07D0, 16'h0040, 16'hBEEF, 16'h0020, 16'h0100};
        c2 = {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        c3 = {16'hAAAA, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        s1 = {16'h4000, 16'h0800, 16'h0000, 16'hF000, 16'h1000};
        s2 = {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        vt[0]  = mkv(8'h00, 5, c0, c0, z, 0, 0, 0);
        vt[1]  = mkv(8'h01, 2, {48'h0, 16'hBEEF, 16'h0002}, c1, z, 0, 0, 0);
        vt[2]  = mkv(8'h01, 2, {48'h0, 16'h1234, 16'h0007}, c1, z, 0, 1, 0);
        vt[3]  = mkv(8'h02, 0, z, c1, z, 0, 0, 0);
        vt[4]  = mkv(8'h5A, 0, z, c1, z, 1, 0, 0);
        vt[5]  = mkv(8'h00, 5, c2, c2, z, 1, 0, 0);
        vt[6]  = mkv(8'h02, 0, z, c2, z, 0, 0, 0);
        vt[7]  = mkv(8'hFF, 5, s1, c2, s1, 0, 0, 1);
        vt[8]  = mkv(8'h01, 2, {48'h0, 16'h0001, 16'h0005}, c2, s1, 0, 1, 1);
        vt[9]  = mkv(8'h01, 2, {48'h0, 16'hAAAA, 16'h0004}, c3, s1, 0, 1, 1);
        vt[10] = mkv(8'hFF, 5, s2, c3, s2, 0, 1, 2);
        vt[11] = mkv(8'h03, 0, z, c3, s2, 1, 1, 2);
        vt[12] = mkv(8'h02, 0, z, c3, s2, 0, 0, 2);
        for (int i = 0; i < 13; i++) begin
            push_op(vt[i].op);
            for (int j = 0; j < vt[i].nd; j++) push_d(vt[i].d[j]);
            wait_idle($sformatf("vec%0d", i), 100);
            check_all($sformatf("vec%0d", i), vt[i].cfg, vt[i].samp, vt[i].eo, vt[i].ei,
                      1'b0, vt[i].fc, 1'b1);
        end

        // ---------------- opcodes wait in the FIFO during WAIT_FOC ----------------
        s3 = {16'h0A05, 16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01};
        bus.foc_ready = 1'b0;
        push_op(8'h77);
        push_op(8'hFF);
        for (int j = 0; j < 5; j++) push_d(s3[j*16 +: 16]);
        push_op(8'h02);
        n = 0;
        while (bus.foc_valid !== 1'b1 && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        chk("hold.valid_seen", 80'(bus.foc_valid), 80'd1);
        repeat (8) @(negedge clk_sys);
        chk("hold.opcode_still_queued", 80'(opq.size()), 80'd1);
        chk("hold.rd_en_opcode", 80'(bus.rd_en_opcode), 80'd0);
        chk("hold.err_opcode", 80'(err_opcode), 80'd1);
        chk("hold.ready", 80'(ready), 80'd0);
`ifndef FOC_CMD_TIMEOUT_EN
        repeat (60) @(negedge clk_sys);
        chk("hold.long_wait_ready", 80'(ready), 80'd0);
        chk("hold.long_wait_err_timeout", 80'(err_timeout), 80'd0);
`endif
        bus.foc_ready = 1'b1;
        wait_idle("hold", 100);
        check_all("hold.done", c3, s3, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1);

        // ---------------- reset in the middle of a starved load ----------------
        push_op(8'h00);
        push_d(16'h9999);
        push_d(16'h8888);
        repeat (50) @(negedge clk_sys);
        chk("starve.data_consumed", 80'(dq.size()), 80'd0);
        chk("starve.cfg_unchanged", cfg_bus, c3);
        rstb = 1'b0;
        #1;
        check_all("midreset", z, z, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        chk("midreset.foc_valid", 80'(bus.foc_valid), 80'd0);
        @(negedge clk_sys);
        rstb = 1'b1;
        @(negedge clk_sys);
        push_op(8'h00);
        for (int j = 0; j < 5; j++) push_d(16'h0011 * 16'(j + 1));
        wait_idle("reload", 100);
        chk("reload.cfg_bus", cfg_bus, {16'h0055, 16'h0044, 16'h0033, 16'h0022, 16'h0011});

`ifdef FOC_CMD_TIMEOUT_EN
        // ---------------- watchdog on the FOC wait ----------------
        bus.foc_ready = 1'b0;
        push_op(8'hFF);
        for (int j = 0; j < 5; j++) push_d(16'h0100 + 16'(j));
        n = 0;
        while (bus.foc_valid !== 1'b1 && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        chk("timeout.valid_seen", 80'(bus.foc_valid), 80'd1);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk("timeout.latency_in_window", 80'(n >= TCYC - 2 && n <= TCYC + 1), 80'd1);
        check_all("timeout", {16'h0055, 16'h0044, 16'h0033, 16'h0022, 16'h0011},
                  {16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100},
                  1'b0, 1'b0, 1'b1, 16'd0, 1'b1);
        bus.foc_ready = 1'b1;
        push_op(8'h02);
        wait_idle("timeout_clear", 100);
        chk("timeout_clear.err_timeout", 80'(err_timeout), 80'd0);
`endif

        // ---------------- randomized command stream ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            m_cfg[i]  = '0;
            m_samp[i] = '0;
        end
        m_eo = 1'b0; m_ei = 1'b0; m_fc = '0;
        v0 = vcount;
        stall_en  = 1'b1;
        rnd_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                push_op(8'h00);
                for (int j = 0; j < 5; j++) begin
                    w = 16'($urandom);
                    push_d(w);
                    m_cfg[j] = w;
                end
            end else if (r <= 4) begin
                idx = 16'($urandom_range(0, 7));
                w   = 16'($urandom);
                push_op(8'h01);
                push_d(idx);
                push_d(w);
                if (idx < 16'd5) m_cfg[idx[2:0]] = w;
                else m_ei = 1'b1;
            end else if (r == 5) begin
                push_op(8'h02);
                m_eo = 1'b0;
                m_ei = 1'b0;
            end else if (r <= 7) begin
                push_op(8'hFF);
                for (int j = 0; j < 5; j++) begin
                    w = 16'($urandom);
                    push_d(w);
                    m_samp[j] = w;
                end
                m_fc = m_fc + 16'd1;
            end else begin
                op = 8'($urandom_range(3, 254));
                push_op(op);
                m_eo = 1'b1;
            end
        end
        wait_idle("random", 6000);
        stall_en  = 1'b0;
        rnd_ready = 1'b0;
        bus.foc_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            pk_cfg[i*16 +: 16]  = m_cfg[i];
            pk_samp[i*16 +: 16] = m_samp[i];
        end
        check_all("random", pk_cfg, pk_samp, m_eo, m_ei, 1'b0, m_fc, 1'b1);
        chk("random.valid_pulses", 80'(vcount - v0), 80'(m_fc));
        chk("random.valid_single_cycle", 80'(vdouble), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/foc_cmd_sequencer.md
FOC_CMD_SEQUENCER -- requirements
Module: foc_cmd_sequencer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16: width of each data word and of each register.
REQ-002 SHALL have parameter N_CFG, default 5: number of configuration registers (kpd, kid, kpq, kiq, periodTop order at default).
REQ-003 SHALL have parameter N_SAMP, default 5: number of sample-frame words (currA, currB, currC, currT, angle order at default).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096: watchdog limit in clk_sys cycles, used only with FOC_CMD_TIMEOUT_EN.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; port clk_sys is input, 1 bit, the system clock.
REQ-006 rstb  input  1  asynchronous active-low reset.
REQ-007 empty_opcode  input  1  opcode FIFO empty; fifo_opcode  input  8  show-ahead opcode head word.
REQ-008 rd_en_opcode  output  1  opcode FIFO pop strobe; pops one word per cycle.
REQ-009 empty_data  input  1  data FIFO empty; fifo_data  input  D_WIDTH  show-ahead data head word.
REQ-010 rd_en_data  output  1  data FIFO pop strobe; pops one word per cycle.
REQ-011 cfg_bus  output  N_CFG*D_WIDTH  committed configuration; register i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-012 samp_bus  output  N_SAMP*D_WIDTH  latched sample frame, packed the same way as cfg_bus.
REQ-013 foc_valid  output  1  one-cycle frame-ready pulse to the FOC core; foc_ready  input  1  FOC core idle/done.
REQ-014 ready  output  1  high when no frame is in flight; err_opcode, err_index, err_timeout  output  1 each  sticky error flags.
REQ-015 frame_cnt  output  16  count of completed frames.

Function
REQ-016 rd_en_opcode SHALL be combinational: high exactly when state=IDLE and !empty_opcode; the head opcode SHALL be decoded in the same cycle.
REQ-017 rd_en_data SHALL be combinational: high exactly when the state is a LOAD state and !empty_data; each pop consumes the head word at that edge.
REQ-018 States SHALL be IDLE, LOAD_CFG, LOAD_IDX, LOAD_ONE, LOAD_SAMP, WAIT_FOC.
REQ-019 In IDLE: opcode 0x00 -> LOAD_CFG (word index=0); 0x01 -> LOAD_IDX; 0x02 -> clear all err flags, stay IDLE; 0xFF -> ready<=0, LOAD_SAMP (index=0).
REQ-020 Any other opcode SHALL be popped and discarded, with err_opcode<=1 and state staying IDLE.
REQ-021 LOAD_CFG SHALL write popped words into shadow[index] for index 0..N_CFG-1; on the pop of word N_CFG-1 it SHALL copy the whole shadow into cfg_bus in one edge and go to IDLE.
REQ-022 cfg_bus SHALL never show a partially loaded set.
REQ-023 LOAD_IDX SHALL pop one word as the target index and go to LOAD_ONE.
REQ-024 LOAD_ONE SHALL pop one word; index<N_CFG -> that cfg_bus register updates directly; index>=N_CFG -> word discarded, err_index<=1; next state IDLE.
REQ-025 LOAD_SAMP SHALL write popped words into samp_bus[index]; on the pop of word N_SAMP-1 it SHALL set foc_valid<=1 and go to WAIT_FOC.
REQ-026 In WAIT_FOC: foc_valid<=0 every cycle; when foc_ready=1 and foc_valid=0 -> ready<=1, frame_cnt<=frame_cnt+1 (wraps 0xFFFF->0), IDLE.
REQ-027 An empty data FIFO SHALL stall any LOAD state indefinitely with no state or register change.
REQ-028 Opcodes SHALL NOT be popped outside IDLE; commands queued during WAIT_FOC SHALL wait in the FIFO.
REQ-029 Error flags SHALL be sticky until opcode 0x02 or reset; a set and a clear in the same cycle cannot occur.

Reset
REQ-030 On rstb low: state=IDLE, cfg_bus=0, shadow=0, samp_bus=0, foc_valid=0, ready=1, all err flags=0, frame_cnt=0, index=0, watchdog=0.
REQ-031 Reset mid-load SHALL discard partial shadow and sample contents; FIFO words already popped SHALL NOT be replayed.

Configuration
REQ-032 With FOC_CMD_TIMEOUT_EN defined: a counter SHALL run in WAIT_FOC; if foc_ready is not accepted within TIMEOUT_CYC cycles of entry, err_timeout<=1, ready<=1, state=IDLE, frame_cnt unchanged.
REQ-033 Without FOC_CMD_TIMEOUT_EN: WAIT_FOC SHALL wait indefinitely and err_timeout SHALL be tied 0.

Verification
REQ-034 Push 0x00 plus data 0x0100,0x0020,0x0200,0x0040,0x07D0 -> cfg_bus unchanged until the 5th pop, then all five appear in the same cycle; no err.
REQ-035 Push 0xFF plus 0x1000,0xF000,0x0000,0x0800,0x4000 with foc_ready held high -> ready low from the opcode pop, one foc_valid pulse after the 5th pop, ready high next, frame_cnt=1.
REQ-036 Push 0x01 with index 7 and value 0x1234 -> err_index=1, cfg_bus unchanged; then 0x02 -> err_index=0.
REQ-037 Push opcode 0x5A -> popped, err_opcode=1, state IDLE; then a valid 0x00 sequence still loads correctly.
REQ-038 Start 0x00 sequence, starve the data FIFO after 2 words for 50 cycles, assert rstb low -> all outputs at reset values, cfg_bus=0.
REQ-039 With FOC_CMD_TIMEOUT_EN and TIMEOUT_CYC=16, send a frame with foc_ready low -> err_timeout=1, ready=1, frame_cnt=0.
